program_loader: RTL

Boot-time loader that sits directly upstream of the single-cycle MIPS core's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them sequentially into instruction memory. It holds the CPU in reset until the whole image is written, then releases it.

---
 rtl/loader_pkg.sv | 23 ++
 rtl/byte_packer.sv | 45 ++++
 rtl/program_loader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and widths for the boot-time program loader.
package loader_pkg;

   localparam int unsigned LOADER_CNT_W = 16;
   localparam int unsigned BYTE_W       = 8;
   localparam int unsigned WORD_W       = 32;
   localparam int unsigned ADDR_W       = 32;

   typedef enum logic [2:0] {
      HDR_HI,
      HDR_LO,
      DATA,
      WRITE,
      DONE,
      ERROR
   } loader_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
   } imem_wr_t;

endpackage

// File: rtl/byte_packer.sv
// Big-endian 4-byte assembler: shifts bytes in MSB first and flags the 4th byte.
module byte_packer
   import loader_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   input  logic              clear,
   output logic [WORD_W-1:0] word_c,
   output logic              word_done_c
);

   localparam int unsigned SR_W = WORD_W - BYTE_W;

   logic [1:0]      idx_q, idx_d;
   logic [SR_W-1:0] sr_q,  sr_d;

   always_comb begin
      idx_d = idx_q;
      sr_d  = sr_q;
      if (clear) begin
         idx_d = '0;
         sr_d  = '0;
      end else if (byte_valid) begin
         sr_d  = {sr_q[SR_W-BYTE_W-1:0], byte_data};
         idx_d = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idx_q <= '0;
         sr_q  <= '0;
      end else begin
         idx_q <= idx_d;
         sr_q  <= sr_d;
      end
   end

   // The full word including the byte being accepted this cycle.
   assign word_c      = {sr_q, byte_data};
   assign word_done_c = byte_valid && (idx_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a counted big-endian byte image, writes it into
// instruction memory word by word, and holds the CPU in reset until complete.
module program_loader
   import loader_pkg::*;
#(
   parameter int unsigned       MAX_WORDS = 256,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [BYTE_W-1:0] rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);

   loader_state_t           state_q, state_d;
   logic [BYTE_W-1:0]       cnt_hi_q, cnt_hi_d;
   logic [LOADER_CNT_W-1:0] count_q, count_d;
   logic [LOADER_CNT_W-1:0] word_idx_q, word_idx_d;
   imem_wr_t                wr_q, wr_d;
   logic                    we_q, we_d;
   logic                    cpu_reset_q, cpu_reset_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;

   logic                    xfer_c;
   logic                    pk_valid_c;
   logic                    pk_clear_c;
   logic [WORD_W-1:0]       pk_word_c;
   logic                    pk_done_c;

   // Ready depends only on registered state, gated low while reset is held.
   assign rx_ready   = reset && ((state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA));
   assign xfer_c     = rx_valid && rx_ready;
   assign pk_valid_c = xfer_c && (state_q == DATA);
   assign pk_clear_c = (state_q == WRITE);

   byte_packer u_packer (
      .clock       (clock),
      .reset       (reset),
      .byte_valid  (pk_valid_c),
      .byte_data   (rx_data),
      .clear       (pk_clear_c),
      .word_c      (pk_word_c),
      .word_done_c (pk_done_c)
   );

   always_comb begin
      state_d    = state_q;
      cnt_hi_d   = cnt_hi_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      wr_d       = wr_q;
      unique case (state_q)
         HDR_HI: begin
            if (xfer_c) begin
               cnt_hi_d = rx_data;
               state_d  = HDR_LO;
            end
         end
         HDR_LO: begin
            if (xfer_c) begin
               count_d    = {cnt_hi_q, rx_data};
               word_idx_d = '0;
               if (count_d == '0)
                  state_d = DONE;
               else if (32'(count_d) > MAX_WORDS)
                  state_d = ERROR;
               else
                  state_d = DATA;
            end
         end
         DATA: begin
            if (pk_done_c) begin
               wr_d.addr = BASE_ADDR + ADDR_W'({word_idx_q, 2'b00});
               wr_d.data = pk_word_c;
               state_d   = WRITE;
            end
         end
         WRITE: begin
            word_idx_d = word_idx_q + LOADER_CNT_W'(1);
            state_d    = (word_idx_d == count_q) ? DONE : DATA;
         end
         DONE:    state_d = DONE;
         ERROR:   state_d = ERROR;
         default: state_d = HDR_HI;
      endcase

      // Status outputs are registered decodes of the next state.
      we_d        = (state_d == WRITE);
      cpu_reset_d = (state_d != DONE);
      done_d      = (state_d == DONE);
      error_d     = (state_d == ERROR);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= HDR_HI;
         cnt_hi_q    <= '0;
         count_q     <= '0;
         word_idx_q  <= '0;
         wr_q.addr   <= BASE_ADDR;
         wr_q.data   <= '0;
         we_q        <= 1'b0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_hi_q    <= cnt_hi_d;
         count_q     <= count_d;
         word_idx_q  <= word_idx_d;
         wr_q        <= wr_d;
         we_q        <= we_d;
         cpu_reset_q <= cpu_reset_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = wr_q.addr;
   assign imem_wdata = wr_q.data;
   assign cpu_reset  = cpu_reset_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule
